store_buffer: RTL and testbench

- Posted-write buffer between the pipeline MEM stage and the data memory (`data_mem`).
- Absorbs stores so the CPU does not pay the two-cycle read-modify-write stall on every store.
- Drains buffered stores to `data_mem` in FIFO order whenever no load needs the memory port.
- Passes loads through unchanged. A load is stalled only while it hits a buffered store's word or while a drain is in flight.

---
 rtl/sail_mem_pkg.sv | 41 ++++
 rtl/store_fifo.sv | 77 +++++++
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sail_mem_pkg.sv
// Shared types and constants for the data-memory store buffer.
// Drain FSM encoding, FIFO entry layout and sign_mask field positions.
package sail_mem_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } drain_state_e;

  // Memory-mapped LED register inside data_mem.
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  // sign_mask layout: [1:0] access size, [2] zero-extend on load.
  localparam int SM_SIZE_LSB = 0;
  localparam int SM_SIZE_MSB = 1;
  localparam int SM_UNSIGNED = 2;

  localparam logic [1:0] SM_BYTE = 2'b00;
  localparam logic [1:0] SM_HALF = 2'b01;
  localparam logic [1:0] SM_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  function automatic logic [1:0] sm_size(
    input logic [3:0] m
  );
    return m[SM_SIZE_MSB:SM_SIZE_LSB];
  endfunction

  function automatic logic sm_unsigned(
    input logic [3:0] m
  );
    return m[SM_UNSIGNED];
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store queue with pointers, occupancy and a parallel
// word-address match vector over the currently valid entries.
// Ports:
//   clk, reset   clock, async active-high reset
//   i_push       enqueue i_entry at the tail
//   i_pop        drop the head entry
//   i_cmp_word   load word address compared against every entry
//   o_head       oldest entry
//   o_full       DEPTH entries held
//   o_empty      no entries held
//   o_match      per-slot hit of a valid entry on i_cmp_word
module store_fifo
  import sail_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CMP_HI = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  sb_entry_t         i_entry,
  input  logic              i_pop,
  input  logic [CMP_HI:2]   i_cmp_word,
  output sb_entry_t         o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [DEPTH-1:0]  o_match
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   w_off [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents need no reset; validity comes from r_count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // Slot g is valid when its distance from the head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_off[g] = AW'(g) - r_rd_ptr;
    assign o_match[g] =
      ({1'b0, w_off[g]} < r_count) &&
      (r_mem[g].addr[CMP_HI:2] == i_cmp_word);
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data_mem; stores are
// queued and drained in order while loads pass straight through.
// Ports:
//   clk, reset        clock, async active-high reset
//   addr/write_data   CPU request address and store data
//   memwrite/memread  CPU store / load strobes (mutually exclusive)
//   sign_mask         CPU size/sign code, forwarded verbatim
//   read_data         load data, copy of mem_read_data
//   clk_stall         CPU must hold its request while high
//   mem_*             data_mem port (address, data, strobes, mask)
//   mem_read_data     data_mem load data, one cycle after mem_memread
//   mem_clk_stall     data_mem busy with a read-modify-write
module store_buffer
  import sail_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CMP_HI = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  drain_state_e       r_state;
  logic               r_drain_we;

  sb_entry_t          w_head;
  sb_entry_t          w_new;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic               w_busy;
  logic               w_st_stall;
  logic               w_ld_stall;
  logic [DEPTH-1:0]   w_match;

  assign w_new = '{addr: addr, data: write_data, mask: sign_mask};

  store_fifo #(
    .DEPTH  (DEPTH),
    .CMP_HI (CMP_HI)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_entry    (w_new),
    .i_pop      (w_pop),
    .i_cmp_word (addr[CMP_HI:2]),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_match    (w_match)
  );

  assign w_busy = (r_state != D_IDLE);
  assign w_pop  = (r_state == D_WAIT) && !mem_clk_stall;
  assign w_hit  = memread && (|w_match);

  // A full buffer still accepts a store on the edge that frees a slot.
  assign w_push = memwrite && (!w_full || w_pop);

  assign w_st_stall = memwrite && w_full && !w_pop;
  assign w_ld_stall = memread && (w_hit || w_busy);
  assign clk_stall  = w_st_stall || w_ld_stall;

  // A hazard load forces a drain even though memread is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= D_IDLE;
      r_drain_we <= 1'b0;
    end else begin
      r_drain_we <= 1'b0;
      unique case (r_state)
        D_IDLE: begin
          if (!w_empty && (!memread || w_hit)) begin
            r_state    <= D_ISSUE;
            r_drain_we <= 1'b1;
          end
        end
        D_ISSUE: begin
          r_state <= D_WAIT;
        end
        D_WAIT: begin
          if (!mem_clk_stall) begin
            r_state <= D_IDLE;
          end
        end
        default: begin
          r_state <= D_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr       = addr;
    mem_write_data = write_data;
    mem_sign_mask  = sign_mask;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    unique case (1'b1)
      w_busy: begin
        mem_addr       = w_head.addr;
        mem_write_data = w_head.data;
        mem_sign_mask  = w_head.mask;
        mem_memwrite   = r_drain_we;
      end
      default: begin
        mem_memread = memread && !w_hit;
      end
    endcase
  end

  assign read_data = mem_read_data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a data_mem model and
// scoreboards for drained writes and returned load data.
module tb_store_buffer;
  import sail_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  logic        minit;
  logic [31:0] dmem [1024];
  logic [7:0]  led;

  logic [67:0] wq [$];
  logic [31:0] rq [$];
  int          we_cyc [$];
  int          cyc = 0;
  logic        rd_pend = 1'b0;
  logic        prev_we = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] MW = {2'b00, SM_WORD};
  localparam logic [3:0] MB = {2'b00, SM_BYTE};

  store_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .write_data     (write_data),
    .memwrite       (memwrite),
    .memread        (memread),
    .sign_mask      (sign_mask),
    .read_data      (read_data),
    .clk_stall      (clk_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // data_mem model: byte/half/word writes, registered reads, LED.
  always @(posedge clk) begin
    if (minit) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'h5000_0000 | i;
      led <= 8'h00;
    end else begin
      if (mem_memwrite) begin
        if (mem_addr == LED_ADDR) begin
          led <= mem_write_data[7:0];
        end else begin
          case (sm_size(mem_sign_mask))
            SM_BYTE: dmem[mem_addr[11:2]][8*mem_addr[1:0] +: 8]
                       <= mem_write_data[7:0];
            SM_HALF: dmem[mem_addr[11:2]][16*mem_addr[1] +: 16]
                       <= mem_write_data[15:0];
            default: dmem[mem_addr[11:2]] <= mem_write_data;
          endcase
        end
      end
      if (mem_memread) mem_read_data <= dmem[mem_addr[11:2]];
    end
  end

  // Output monitor: drained writes and returned load data.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend) begin
      chk("rd_q", rq.size() != 0, 1);
      if (rq.size() != 0) chk("rd_data", read_data, rq.pop_front());
    end
    if (mem_memwrite) begin
      chk("we_1cyc", prev_we, 0);
      chk("wr_q", wq.size() != 0, 1);
      if (wq.size() != 0)
        chk("wr_entry", {mem_addr, mem_write_data, mem_sign_mask},
            wq.pop_front());
      we_cyc.push_back(cyc);
    end
    rd_pend <= mem_memread;
    prev_we <= mem_memwrite;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int exp_stall);
    int n = 0;
    addr = a; write_data = d; sign_mask = m; memwrite = 1'b1;
    @(negedge clk);
    while (clk_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("st_stall", n, exp_stall);
    wq.push_back({a, d, m});
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp,
                         input int exp_stall);
    int n = 0;
    addr = a; sign_mask = MW; memread = 1'b1;
    @(negedge clk);
    while (clk_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("ld_stall", n, exp_stall);
    chk("ld_issue", mem_memread, 1);
    chk("ld_addr", mem_addr, a);
    rq.push_back(exp);
    tick();
    memread = 1'b0;
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((dut.u_fifo.r_count != 0 || dut.r_state != D_IDLE)
           && n < 100) begin
      tick();
      n++;
    end
    chk("drain_bound", n < 100, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; minit = 1'b1;
    addr = '0; write_data = '0; sign_mask = '0;
    memwrite = 1'b0; memread = 1'b0; mem_clk_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    minit = 1'b0;
    @(negedge clk);
    chk("rst_stall", clk_stall, 0);
    chk("rst_we", mem_memwrite, 0);
    chk("rst_re", mem_memread, 0);
    chk("rst_cnt", dut.u_fifo.r_count, 0);
    chk("rst_fsm", dut.r_state, D_IDLE);
    tick();
    reset = 1'b0;

    // Four zero-stall stores; data_mem busy keeps them queued.
    mem_clk_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), MW, 0);

    // Fifth store against a full buffer.
    addr = 32'h110; write_data = 32'hA4; sign_mask = MW; memwrite = 1'b1;
    @(negedge clk);
    chk("full_cnt", dut.u_fifo.r_count, 4);
    chk("full_stall0", clk_stall, 1);
    tick();
    @(negedge clk);
    chk("full_stall1", clk_stall, 1);
    tick();
    mem_clk_stall = 1'b0;
    @(negedge clk);
    chk("full_release", clk_stall, 0);
    wq.push_back({32'h110, 32'hA4, MW});
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    chk("full_cnt_hold", dut.u_fifo.r_count, 4);
    wait_drain();
    chk("drain_n", we_cyc.size(), 5);
    if (we_cyc.size() == 5)
      for (int i = 1; i < 4; i++)
        chk("drain_gap", we_cyc[i+1] - we_cyc[i], 3);

    // Load hitting a just-stored word waits for its drain.
    do_store(32'h200, 32'h1234_5678, MW, 0);
    do_load(32'h200, 32'h1234_5678, 3);
    wait_drain();

    // Unrelated load during a drain waits only for D_IDLE.
    do_store(32'h203, 32'hFF, MB, 0);
    tick();
    do_load(32'h300, 32'h5000_00C0, 2);
    wait_drain();

    // Load to a different byte of a buffered word stalls on match.
    do_store(32'h203, 32'hEE, MB, 0);
    do_load(32'h201, 32'hEE34_5678, 3);
    wait_drain();

    // LED changes on drain, not on CPU issue.
    do_store(LED_ADDR, 32'h5A, MW, 0);
    @(negedge clk);
    chk("led_early", led, 8'h00);
    wait_drain();
    tick();
    chk("led_late", led, 8'h5A);

    // Reset while the head store sits in D_WAIT.
    mem_clk_stall = 1'b1;
    do_store(32'h400, 32'h11, MW, 0);
    do_store(32'h404, 32'h22, MW, 0);
    do_store(32'h408, 32'h33, MW, 0);
    @(negedge clk);
    chk("mid_cnt", dut.u_fifo.r_count, 3);
    chk("mid_fsm", dut.r_state, D_WAIT);
    tick();
    reset = 1'b1;
    #1;
    wq.delete();
    chk("mrst_cnt", dut.u_fifo.r_count, 0);
    chk("mrst_fsm", dut.r_state, D_IDLE);
    chk("mrst_stall", clk_stall, 0);
    chk("mrst_we", mem_memwrite, 0);
    tick();
    reset = 1'b0;
    mem_clk_stall = 1'b0;
    do_load(32'h100, 32'hA0, 0);

    repeat (3) tick();
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    chk("idle_we", mem_memwrite, 0);
    chk("idle_re", mem_memread, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
